nf_fetch_unit: RTL and testbench
================================

// Module: nf_fetch_unit
//
// PURPOSE
//  Instruction fetch stage and IF/ID pipeline register for the nanoFOX pipeline.
//  - Owns the PC and issues one word request at a time to instruction memory.
//  - Delivers instr/pc/valid to the decode stage.
//  - Obeys the hazard unit's fetch-enable and decode-stall outputs, and the EXE branch redirect.
//  - Sits directly upstream of decode.
//
// PARAMETERS
//  RESET_PC   32'h0000_0000   PC of the first fetch after reset; bits [1:0] must be 0
//
// PORTS
//  clk            in   1    clock; all state updates on the rising edge
//  rst            in   1    asynchronous reset, active-high
//  en_if          in   1    1 = a new fetch may be issued; 0 = issue nothing new
//  stall_id       in   1    1 = decode holds; the IF/ID register must not change
//  branch_taken   in   1    1-cycle redirect pulse from EXE
//  branch_target  in   32   redirect PC; bits [1:0] are ignored and forced to 0
//  addr_i         out  32   instruction memory word address
//  req_i          out  1    request valid
//  ack_i          in   1    1-cycle acknowledge, arriving 1..N cycles after req_i is sampled
//  rd_i           in   32   instruction data, valid when ack_i = 1
//  instr_id       out  32   instruction presented to decode
//  pc_id          out  32   PC of instr_id
//  valid_id       out  1    instr_id is a real instruction; 0 means bubble
//
// BEHAVIOUR
//  - Reset values: pc = RESET_PC, addr_i = RESET_PC, req_i = 0, instr_id = NOP (32'h0000_0013),
//    pc_id = 0, valid_id = 0, buffer empty, FSM = IDLE.
//  - FSM states: IDLE, REQ, DROP.
//    - IDLE -> REQ when en_if = 1 and the buffer is empty.
//    - REQ: req_i = 1 and addr_i = pc, both held stable until ack_i. Only one request is outstanding.
//    - REQ on ack_i:
//      - pc <= pc + 4, modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
//      - Go to REQ again if en_if = 1 and the buffer will be empty; otherwise go to IDLE.
//    - DROP: an old request is still outstanding after a redirect. On its ack_i, discard rd_i,
//      then go to REQ at the new pc.
//  - IF/ID register update (the register and ack_i are evaluated in the same cycle):
//    - stall_id = 0, buffer full -> load from the buffer and empty it. A same-cycle ack goes into the buffer.
//    - stall_id = 0, buffer empty, ack_i (not DROP) -> load rd_i/pc, valid_id = 1. Zero-cycle pass-through.
//    - stall_id = 0, no data -> load NOP, valid_id = 0 (bubble).
//    - stall_id = 1 -> hold. An ack_i in this cycle is written into the 1-entry buffer.
//    - Buffer full -> req_i is not raised, so the buffer can never overflow.
//  - Redirect (branch_taken = 1) has priority over stall_id and over en_if:
//    - pc <= {branch_target[31:2], 2'b00}; the buffer is flushed.
//    - IF/ID register <= NOP, valid_id = 0, pc_id = 0.
//    - If in REQ with no ack this cycle -> DROP. If ack_i in the same cycle -> discard rd_i and go to REQ.
//    - If in IDLE -> REQ next cycle, provided en_if = 1.
//    - A redirect while already in DROP stays in DROP and only updates pc.
//  - en_if = 0 while a request is outstanding: the request completes normally; it is not cancelled.
//  - Reset mid-request: everything returns to reset values immediately. Memory must tolerate the abandoned request.
//  - Latency: with memory ack in the next cycle, en_if = 1 and no stalls, there is 1 instruction per 2 cycles
//    (single outstanding request, intended).
//
// CONFIGURATION
//  NF_FETCH_PERF_EN
//  - Defined: adds output port fetch_wait_cnt [31:0].
//    - Counts cycles with req_i = 1 and ack_i = 0.
//    - Reset value 0; saturates at 32'hFFFF_FFFF.
//  - Undefined: the port and the counter do not exist. All other behaviour is identical.
//
// STRUCTURE
//  - nf_fetch_pkg holds:
//    - typedef enum logic [1:0] { IDLE, REQ, DROP } nf_fetch_st_t
//    - NF_NOP = 32'h0000_0013
//    - NF_PC_INC = 32'd4
//  - Sub-module nf_fetch_buf: 1-entry instr/pc holding buffer with wr, rd and flush inputs and a full flag.
//  - The FSM, PC and IF/ID register stay in the top level.
//
// TESTING
//  1. Reset:
//     - rst pulse -> req_i = 0, valid_id = 0, instr_id = 32'h13.
//     - After release, addr_i = RESET_PC with req_i = 1.
//  2. Straight line:
//     - Memory acks 1 cycle later with rd_i = pc ^ 32'hA5A5_0000.
//     - Expect pc_id = 0, 4, 8 in order with matching instr_id and valid_id = 1.
//  3. Stall buffering:
//     - Assert stall_id for 3 cycles across an ack of pc 8.
//     - Expect IF/ID held, req_i = 0 while the buffer is full.
//     - On release, pc 8 appears first, then pc 12; nothing is lost or duplicated.
//  4. Redirect during wait:
//     - branch_taken with target 32'h0000_0103 while a request to 16 is outstanding (ack delayed 3 cycles).
//     - Expect the late data to be dropped and valid_id = 0.
//     - The next addr_i is 32'h0000_0100, and pc_id = 0x100 is the next valid instruction.
//  5. Redirect with same-cycle ack and stall_id = 1:
//     - Expect a flush to a bubble, the acked data discarded, and a fetch at the target next cycle.
//  6. Wrap and perf:
//     - Redirect to 32'hFFFF_FFFC -> next fetch addr 0.
//     - With NF_FETCH_PERF_EN, a 3-cycle ack delay gives fetch_wait_cnt += 3.

Source files
------------

// File: rtl/nf_fetch_pkg.sv
// nanoFOX fetch stage: shared types and constants.
// Used by nf_fetch_buf and nf_fetch_unit.
package nf_fetch_pkg;

    // Fetch FSM: IDLE = nothing outstanding, REQ = live request,
    // DROP = stale request outstanding whose data must be discarded.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } nf_fetch_st_t;

    localparam logic [31:0] NF_NOP    = 32'h0000_0013;
    localparam logic [31:0] NF_PC_INC = 32'd4;

    // Word-align an address. The whole vector is masked so that the low
    // bits count as consumed rather than silently dropped.
    function automatic logic [31:0] nf_align(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/nf_fetch_buf.sv
// nanoFOX fetch stage: 1-entry instr/pc holding buffer.
// Catches an instruction that returns while decode is stalled (or while an
// older buffered instruction is being drained).
// Priority: flush > write > read. A write with a same-cycle read leaves the
// buffer full with the new entry.
module nf_fetch_buf
    import nf_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_wr,
    input  logic        i_rd,
    input  logic        i_flush,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic        o_full
);

    logic        r_full;
    logic [31:0] r_instr;
    logic [31:0] r_pc;

    // Entry storage and occupancy flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full  <= 1'b0;
            r_instr <= NF_NOP;
            r_pc    <= 32'd0;
        end else if (i_flush) begin
            r_full  <= 1'b0;
        end else if (i_wr) begin
            r_full  <= 1'b1;
            r_instr <= i_instr;
            r_pc    <= i_pc;
        end else if (i_rd) begin
            r_full  <= 1'b0;
        end
    end

    assign o_instr = r_instr;
    assign o_pc    = r_pc;
    assign o_full  = r_full;

endmodule

// File: rtl/nf_fetch_unit.sv
// nanoFOX instruction fetch stage with IF/ID pipeline register.
// Optional feature macro: NF_FETCH_PERF_EN adds fetch_wait_cnt, a saturating
// count of cycles spent with req_i = 1 and ack_i = 0.
//
// Memory handshake: req_i/addr_i are driven from registered state only and
// stay stable from the cycle req_i rises until the cycle ack_i = 1 is seen;
// ack_i is a single-cycle pulse and rd_i is valid only in that cycle. At most
// one request is outstanding. In DROP the old address is held until its ack.
module nf_fetch_unit
    import nf_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_if,
    input  logic         stall_id,
    input  logic         branch_taken,
    input  logic [31:0]  branch_target,
    output logic [31:0]  addr_i,
    output logic         req_i,
    input  logic         ack_i,
    input  logic [31:0]  rd_i,
    output logic [31:0]  instr_id,
    output logic [31:0]  pc_id,
    output logic         valid_id,
`ifdef NF_FETCH_PERF_EN
    output logic [31:0]  fetch_wait_cnt,
`endif
    output nf_fetch_st_t dbg_state
);

    nf_fetch_st_t r_state;
    nf_fetch_st_t w_state_next;

    logic [31:0] r_pc;
    logic [31:0] r_drop_addr;
    logic [31:0] r_instr_id;
    logic [31:0] r_pc_id;
    logic        r_valid_id;

    logic        w_ack_req;
    logic        w_buf_wr;
    logic        w_buf_rd;
    logic        w_buf_full;
    logic        w_buf_full_next;
    logic [31:0] w_buf_instr;
    logic [31:0] w_buf_pc;

    // An ack only carries useful data while in REQ; acks in DROP are stale.
    assign w_ack_req = ack_i && (r_state == REQ);

    // Park returning data when decode cannot take it this cycle.
    assign w_buf_wr = w_ack_req && !branch_taken && (stall_id || w_buf_full);
    assign w_buf_rd = !branch_taken && !stall_id && w_buf_full;

    // Occupancy after this edge; used to decide whether to issue back-to-back.
    assign w_buf_full_next = !branch_taken && (w_buf_wr || (w_buf_full && stall_id));

    nf_fetch_buf u_buf (
        .clk     (clk),
        .rst     (rst),
        .i_wr    (w_buf_wr),
        .i_rd    (w_buf_rd),
        .i_flush (branch_taken),
        .i_instr (rd_i),
        .i_pc    (r_pc),
        .o_instr (w_buf_instr),
        .o_pc    (w_buf_pc),
        .o_full  (w_buf_full)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    // FSM next-state: redirect wins over en_if; buffer full blocks new issue.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (en_if && (branch_taken || !w_buf_full)) w_state_next = REQ;
            end
            REQ: begin
                if (branch_taken) begin
                    w_state_next = ack_i ? REQ : DROP;
                end else if (ack_i) begin
                    w_state_next = (en_if && !w_buf_full_next) ? REQ : IDLE;
                end
            end
            DROP: begin
                if (ack_i) w_state_next = REQ;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // PC: redirect target, else advance on a live ack (wraps modulo 2^32).
    always_ff @(posedge clk or posedge rst) begin
        if (rst)               r_pc <= RESET_PC;
        else if (branch_taken) r_pc <= nf_align(branch_target);
        else if (w_ack_req)    r_pc <= r_pc + NF_PC_INC;
    end

    // Remember the in-flight address so addr_i stays stable through DROP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                             r_drop_addr <= RESET_PC;
        else if (branch_taken && (r_state == REQ) && !ack_i) r_drop_addr <= r_pc;
    end

    assign req_i  = (r_state == REQ) || (r_state == DROP);
    assign addr_i = (r_state == DROP) ? r_drop_addr : r_pc;

    // IF/ID register: flush, hold, drain buffer, pass through, or bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instr_id <= NF_NOP;
            r_pc_id    <= 32'd0;
            r_valid_id <= 1'b0;
        end else if (branch_taken) begin
            r_instr_id <= NF_NOP;
            r_pc_id    <= 32'd0;
            r_valid_id <= 1'b0;
        end else if (!stall_id) begin
            if (w_buf_full) begin
                r_instr_id <= w_buf_instr;
                r_pc_id    <= w_buf_pc;
                r_valid_id <= 1'b1;
            end else if (w_ack_req) begin
                r_instr_id <= rd_i;
                r_pc_id    <= r_pc;
                r_valid_id <= 1'b1;
            end else begin
                r_instr_id <= NF_NOP;
                r_pc_id    <= 32'd0;
                r_valid_id <= 1'b0;
            end
        end
    end

    assign instr_id  = r_instr_id;
    assign pc_id     = r_pc_id;
    assign valid_id  = r_valid_id;
    assign dbg_state = r_state;

`ifdef NF_FETCH_PERF_EN
    logic [31:0] r_wait_cnt;

    // Saturating count of cycles waiting on memory.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                          r_wait_cnt <= 32'd0;
        else if (req_i && !ack_i && (r_wait_cnt != '1))   r_wait_cnt <= r_wait_cnt + 32'd1;
    end

    assign fetch_wait_cnt = r_wait_cnt;
`endif

endmodule

// File: tb/tb_nf_fetch_unit.sv
// Directed bench for nf_fetch_unit: a per-cycle vector table plus
// hand-written wrap / perf-counter / mid-request reset sequences.
// Build with NF_FETCH_PERF_EN defined to also check fetch_wait_cnt.
module tb_nf_fetch_unit;
  import nf_fetch_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic         clk = 1'b0;
  logic         rst;
  logic         en_if;
  logic         stall_id;
  logic         branch_taken;
  logic [31:0]  branch_target;
  logic [31:0]  addr_i;
  logic         req_i;
  logic         ack_i;
  logic [31:0]  rd_i;
  logic [31:0]  instr_id;
  logic [31:0]  pc_id;
  logic         valid_id;
  nf_fetch_st_t dbg_state;
`ifdef NF_FETCH_PERF_EN
  logic [31:0]  fetch_wait_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  // clock / reset
  always #5 clk = ~clk;

  nf_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .en_if         (en_if),
    .stall_id      (stall_id),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .addr_i        (addr_i),
    .req_i         (req_i),
    .ack_i         (ack_i),
    .rd_i          (rd_i),
    .instr_id      (instr_id),
    .pc_id         (pc_id),
    .valid_id      (valid_id),
`ifdef NF_FETCH_PERF_EN
    .fetch_wait_cnt(fetch_wait_cnt),
`endif
    .dbg_state     (dbg_state)
  );

  typedef struct {
    logic         en;
    logic         st;
    logic         br;
    logic [31:0]  tgt;
    logic         ack;
    logic [31:0]  rd;
    logic         e_req;
    logic [31:0]  e_addr;
    logic         e_val;
    logic [31:0]  e_pc;
    logic         chk_pc;
    logic [31:0]  e_instr;
    nf_fetch_st_t e_st;
  } vec_t;

  vec_t vecs [0:25];

  function automatic logic [31:0] dat(input logic [31:0] p);
    return p ^ 32'hA5A5_0000;
  endfunction

  function automatic vec_t mk(input logic en, input logic st, input logic br,
                              input logic [31:0] tgt, input logic ack, input logic [31:0] rd,
                              input logic e_req, input logic [31:0] e_addr, input logic e_val,
                              input logic [31:0] e_pc, input logic chk_pc,
                              input logic [31:0] e_instr, input nf_fetch_st_t e_st);
    vec_t v;
    v.en = en; v.st = st; v.br = br; v.tgt = tgt; v.ack = ack; v.rd = rd;
    v.e_req = e_req; v.e_addr = e_addr; v.e_val = e_val; v.e_pc = e_pc;
    v.chk_pc = chk_pc; v.e_instr = e_instr; v.e_st = e_st;
    return v;
  endfunction

  // driver
  task automatic drive(input vec_t v);
    en_if         = v.en;
    stall_id      = v.st;
    branch_taken  = v.br;
    branch_target = v.tgt;
    ack_i         = v.ack;
    rd_i          = v.rd;
  endtask

  // scoreboard compare of the current DUT outputs against one record
  task automatic check(input string name, input vec_t v);
    logic bad;
    bad = (req_i !== v.e_req) || (addr_i !== v.e_addr) || (valid_id !== v.e_val) ||
          (instr_id !== v.e_instr) || (dbg_state !== v.e_st) ||
          ((v.e_val || v.chk_pc) && (pc_id !== v.e_pc));
    n_vec++;
    if (bad) begin
      n_err++;
      $display("FAIL %s: got req=%0b addr=%h valid=%0b pc=%h instr=%h st=%0d, want req=%0b addr=%h valid=%0b pc=%h instr=%h st=%0d",
               name, req_i, addr_i, valid_id, pc_id, instr_id, dbg_state,
               v.e_req, v.e_addr, v.e_val, v.e_pc, v.e_instr, v.e_st);
    end
  endtask

  task automatic apply(input string name, input vec_t v);
    @(negedge clk);
    drive(v);
    #1;
    check(name, v);
  endtask

  task automatic check_cnt(input string name, input logic [31:0] exp_cnt);
`ifdef NF_FETCH_PERF_EN
    n_vec++;
    if (fetch_wait_cnt !== exp_cnt) begin
      n_err++;
      $display("FAIL %s: got fetch_wait_cnt=%0d, want %0d", name, fetch_wait_cnt, exp_cnt);
    end
`else
    if (name.len() == 0 && exp_cnt == 32'd1) $display("unused");
`endif
  endtask

  initial begin
    // per-cycle table: inputs | req addr valid pc chk_pc instr state
    vecs[0]  = mk(1,0,0,0,0,0,            0,32'h000,0,0,1,NOP,IDLE);
    vecs[1]  = mk(1,0,0,0,0,0,            1,32'h000,0,0,0,NOP,REQ);
    vecs[2]  = mk(1,0,0,0,1,dat(32'h000), 1,32'h000,0,0,0,NOP,REQ);
    vecs[3]  = mk(1,0,0,0,0,0,            1,32'h004,1,32'h000,0,dat(32'h000),REQ);
    vecs[4]  = mk(1,0,0,0,1,dat(32'h004), 1,32'h004,0,0,0,NOP,REQ);
    vecs[5]  = mk(1,1,0,0,0,0,            1,32'h008,1,32'h004,0,dat(32'h004),REQ);
    vecs[6]  = mk(1,1,0,0,1,dat(32'h008), 1,32'h008,1,32'h004,0,dat(32'h004),REQ);
    vecs[7]  = mk(1,1,0,0,0,0,            0,32'h00C,1,32'h004,0,dat(32'h004),IDLE);
    vecs[8]  = mk(1,0,0,0,0,0,            0,32'h00C,1,32'h004,0,dat(32'h004),IDLE);
    vecs[9]  = mk(1,0,0,0,0,0,            0,32'h00C,1,32'h008,0,dat(32'h008),IDLE);
    vecs[10] = mk(1,0,0,0,0,0,            1,32'h00C,0,0,0,NOP,REQ);
    vecs[11] = mk(1,0,0,0,1,dat(32'h00C), 1,32'h00C,0,0,0,NOP,REQ);
    vecs[12] = mk(1,0,0,0,0,0,            1,32'h010,1,32'h00C,0,dat(32'h00C),REQ);
    vecs[13] = mk(1,0,1,32'h103,0,0,      1,32'h010,0,0,0,NOP,REQ);
    vecs[14] = mk(1,0,0,0,0,0,            1,32'h010,0,0,1,NOP,DROP);
    vecs[15] = mk(1,0,0,0,1,dat(32'h010), 1,32'h010,0,0,0,NOP,DROP);
    vecs[16] = mk(1,0,0,0,0,0,            1,32'h100,0,0,0,NOP,REQ);
    vecs[17] = mk(1,0,0,0,1,dat(32'h100), 1,32'h100,0,0,0,NOP,REQ);
    vecs[18] = mk(1,1,0,0,0,0,            1,32'h104,1,32'h100,0,dat(32'h100),REQ);
    vecs[19] = mk(1,1,1,32'h200,1,dat(32'h104), 1,32'h104,1,32'h100,0,dat(32'h100),REQ);
    vecs[20] = mk(1,0,0,0,0,0,            1,32'h200,0,0,1,NOP,REQ);
    vecs[21] = mk(1,0,0,0,1,dat(32'h200), 1,32'h200,0,0,0,NOP,REQ);
    vecs[22] = mk(0,0,0,0,0,0,            1,32'h204,1,32'h200,0,dat(32'h200),REQ);
    vecs[23] = mk(0,0,0,0,1,dat(32'h204), 1,32'h204,0,0,0,NOP,REQ);
    vecs[24] = mk(0,0,0,0,0,0,            0,32'h208,1,32'h204,0,dat(32'h204),IDLE);
    vecs[25] = mk(0,0,0,0,0,0,            0,32'h208,0,0,0,NOP,IDLE);

    // reset
    rst = 1'b1;
    drive(mk(0,0,0,0,0,0, 0,0,0,0,0,NOP,IDLE));
    repeat (2) @(negedge clk);
    #1;
    check("reset", mk(0,0,0,0,0,0, 0,32'h0,0,32'h0,1,NOP,IDLE));
    check_cnt("reset_cnt", 32'd0);
    rst = 1'b0;

    // straight line, stall buffering, redirects, en_if drop
    for (int i = 0; i < 26; i++) apply($sformatf("vec%0d", i), vecs[i]);

    // redirect to the last word, then wrap to 0; 3-cycle ack delay for perf
    apply("wrap0", mk(1,0,1,32'hFFFF_FFFF,0,0, 0,32'h208,0,0,0,NOP,IDLE));
    apply("wrap1", mk(1,0,0,0,0,0, 1,32'hFFFF_FFFC,0,0,0,NOP,REQ));
    apply("wrap2", mk(1,0,0,0,1,32'hDEAD_0001, 1,32'hFFFF_FFFC,0,0,0,NOP,REQ));
    apply("wrap3", mk(1,0,0,0,0,0, 1,32'h0,1,32'hFFFF_FFFC,0,32'hDEAD_0001,REQ));
    check_cnt("perf_before", 32'd12);
    apply("wrap4", mk(1,0,0,0,0,0, 1,32'h0,0,0,0,NOP,REQ));
    apply("wrap5", mk(1,0,0,0,0,0, 1,32'h0,0,0,0,NOP,REQ));
    apply("wrap6", mk(1,0,0,0,1,dat(32'h0), 1,32'h0,0,0,0,NOP,REQ));
    check_cnt("perf_after", 32'd15);

    // asynchronous reset while a request to 4 is outstanding
    @(negedge clk);
    drive(mk(0,0,0,0,0,0, 0,0,0,0,0,NOP,IDLE));
    #2 rst = 1'b1;
    #1;
    check("midreset", mk(0,0,0,0,0,0, 0,32'h0,0,32'h0,1,NOP,IDLE));
    check_cnt("midreset_cnt", 32'd0);
    @(negedge clk);
    rst = 1'b0;
    apply("restart0", mk(1,0,0,0,0,0, 0,32'h0,0,32'h0,1,NOP,IDLE));
    apply("restart1", mk(1,0,0,0,0,0, 1,32'h0,0,0,0,NOP,REQ));

    // report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
